// File: rtl/mips_defs_pkg.sv
// Shared MIPS EX-stage definitions: multiply/divide op encodings and sequencer FSM states.
package mips_defs;

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_MULT  = 2'd1,
    OP_DIVU  = 2'd2,
    OP_DIV   = 2'd3
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // Bit 1 of the encoding selects divide, bit 0 selects the signed variant.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {acc, q} pair: shift-add for multiply, trial-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, m};
    shifted  = {acc, q[WIDTH-1]};
    diff     = shifted - {1'b0, m};
    acc_next = acc;
    q_next   = q;
    if (!is_div) begin
      // Multiplier bits retire from q[0]; product bits shift in from the top.
      if (q[0]) {acc_next, q_next} = {sum, q[WIDTH-1:1]};
      else      {acc_next, q_next} = {1'b0, acc, q[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_next = diff[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO; runs WIDTH iterations per op and requests
// pipeline stalls while an op is in flight and the EX stage needs the unit or HI/LO.
module muldiv_sequencer
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [1:0]       ctrl_muldiv_op,
  input  logic             ctrl_hilo_read,
  input  logic             ctrl_flush,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state, state_next;
  muldiv_op_e         op_q;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   acc, q, m;
  logic [WIDTH-1:0]   acc_step, q_step;
  logic               neg_lo, neg_hi;
  logic               accept, start_div, start_signed, start_div0;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] prod, prod_neg;

  // Handshake: an op is taken only when IDLE sees ctrl_start without ctrl_flush; while busy
  // the requester is held by stall_req and its start is ignored until the unit is IDLE again.
  assign accept       = (state == ST_IDLE) && ctrl_start && !ctrl_flush;
  assign start_div    = op_is_div(ctrl_muldiv_op);
  assign start_signed = op_is_signed(ctrl_muldiv_op);
  assign start_div0   = start_div && (rt_data == '0);
  assign rs_mag       = (start_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign rt_mag       = (start_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
  assign prod         = {acc, q};
  assign prod_neg     = -prod;
  assign stall_req    = busy && (ctrl_start || ctrl_hilo_read);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_is_div(op_q)),
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_step),
    .q_next   (q_step)
  );

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_next = start_div0 ? ST_DONE : ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (count == CW'(WIDTH - 1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = !ctrl_flush;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (ctrl_flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      op_q        <= OP_MULTU;
      count       <= '0;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: if (accept) begin
          op_q        <= muldiv_op_e'(ctrl_muldiv_op);
          count       <= '0;
          div_by_zero <= start_div0;
          if (start_div0) begin
            // Preload the divide-by-zero result so DONE writes it with no sign fixup.
            acc    <= rs_data;
            q      <= '1;
            m      <= rt_data;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
          end else begin
            acc    <= '0;
            q      <= start_div ? rs_mag : rt_mag;
            m      <= start_div ? rt_mag : rs_mag;
            neg_lo <= start_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_hi <= start_signed && rs_data[WIDTH-1];
          end
        end
        ST_RUN: begin
          acc   <= acc_step;
          q     <= q_step;
          count <= count + CW'(1);
        end
        ST_DONE: if (!ctrl_flush) begin
          if (!op_is_div(op_q)) begin
            {hi, lo} <= neg_lo ? prod_neg : prod;
          end else begin
            hi <= neg_hi ? -acc : acc;
            lo <= neg_lo ? -q : q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed results, latency, stall, flush and reset.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         ctrl_start;
  logic [1:0]   ctrl_muldiv_op;
  logic         ctrl_hilo_read;
  logic         ctrl_flush;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         busy;
  logic         done;
  logic         stall_req;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_vec = 0;
  int n_bad = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clock = ~clock;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_muldiv_op (ctrl_muldiv_op),
    .ctrl_hilo_read (ctrl_hilo_read),
    .ctrl_flush     (ctrl_flush),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .busy           (busy),
    .done           (done),
    .stall_req      (stall_req),
    .div_by_zero    (div_by_zero),
    .hi             (hi),
    .lo             (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Each cycle starts 1ns after the rising edge; inputs are set then, outputs read 1ns later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ctrl_start     = 1'b0;
    ctrl_muldiv_op = 2'd0;
    ctrl_hilo_read = 1'b0;
    ctrl_flush     = 1'b0;
    rs_data        = '0;
    rt_data        = '0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input int exp_dc);
    int dc;
    logic [2*W-1:0] exp_hl;
    exp_q.push_back({exp_hi, exp_lo});
    ctrl_start = 1'b1; ctrl_muldiv_op = op; rs_data = a; rt_data = b;
    #1;
    check_eq({tag, "_idle_stall"}, 64'(stall_req), 64'd0);
    dc = -1;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      next_cycle();
      ctrl_start = 1'b0;
      #1;
      if (done) dc = c;
    end
    check_eq({tag, "_done_cycle"}, 64'(dc), 64'(exp_dc));
    next_cycle();
    #1;
    exp_hl = exp_q.pop_front();
    check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
    check_eq({tag, "_hi"}, 64'(hi), 64'(exp_hl[2*W-1:W]));
    check_eq({tag, "_lo"}, 64'(lo), 64'(exp_hl[W-1:0]));
  endtask

  // Starts an op, flushes it at cycle fc, and confirms it leaves no trace on hi/lo.
  task automatic flush_at(input string tag, input int fc, input logic [W-1:0] keep_hi,
                          input logic [W-1:0] keep_lo);
    logic seen_done;
    seen_done = 1'b0;
    ctrl_start = 1'b1; ctrl_muldiv_op = 2'd0; rs_data = 32'd5; rt_data = 32'd5;
    #1;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      ctrl_start = 1'b0;
      if (c == fc) ctrl_flush = 1'b1;
      if (c == fc + 1) ctrl_flush = 1'b0;
      #1;
      if (c == fc + 1) check_eq({tag, "_busy_next"}, 64'(busy), 64'd0);
      if (done) seen_done = 1'b1;
    end
    check_eq({tag, "_no_done"}, 64'(seen_done), 64'd0);
    check_eq({tag, "_hi_kept"}, 64'(hi), 64'(keep_hi));
    check_eq({tag, "_lo_kept"}, 64'(lo), 64'(keep_lo));
  endtask

  initial begin
    int dc;
    idle_inputs();
    reset = 1'b1;
    repeat (3) next_cycle();
    reset = 1'b0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_stall", 64'(stall_req), 64'd0);
    check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    next_cycle();

    run_op("multu_7x6", 2'd0, 32'd7, 32'd6, 32'd0, 32'd42, 33);
    run_op("mult_m3x5", 2'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 33);
    run_op("multu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    run_op("divu_100_7", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op("div_m7_2", 2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_op("div_7_m2", 2'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33);
    check_eq("dbz_clear0", 64'(div_by_zero), 64'd0);
    run_op("div_5_0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1);
    check_eq("dbz_set", 64'(div_by_zero), 64'd1);
    run_op("div_minneg", 2'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);
    check_eq("dbz_cleared", 64'(div_by_zero), 64'd0);

    // MFHI arrives mid-multiply, then a second start piles up behind it.
    ctrl_start = 1'b1; ctrl_muldiv_op = 2'd0; rs_data = 32'd3; rt_data = 32'd4;
    #1;
    dc = -1;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      next_cycle();
      if (c == 1) ctrl_start = 1'b0;
      if (c == 10) ctrl_hilo_read = 1'b1;
      if (c == 12) begin
        ctrl_start = 1'b1; ctrl_muldiv_op = 2'd2; rs_data = 32'd9; rt_data = 32'd3;
      end
      #1;
      if (c == 5) check_eq("stall_quiet", 64'(stall_req), 64'd0);
      if (c == 10) check_eq("stall_mfhi", 64'(stall_req), 64'd1);
      if (c == 12) check_eq("stall_start", 64'(stall_req), 64'd1);
      if (done) begin
        dc = c;
        check_eq("stall_in_done", 64'(stall_req), 64'd1);
      end
    end
    check_eq("stall_done_cycle", 64'(dc), 64'd33);
    next_cycle();
    #1;
    check_eq("stall_idle", 64'(stall_req), 64'd0);
    check_eq("stall_lo_first_op", 64'(lo), 64'd12);
    idle_inputs();
    next_cycle();
    #1;
    check_eq("stall_second_ignored", 64'(busy), 64'd0);

    flush_at("flush_c15", 15, 32'd0, 32'd12);
    flush_at("flush_in_done", 33, 32'd0, 32'd12);

    ctrl_start = 1'b1; ctrl_flush = 1'b1; rs_data = 32'd2; rt_data = 32'd2;
    next_cycle();
    idle_inputs();
    #1;
    check_eq("flush_start_busy", 64'(busy), 64'd0);
    repeat (3) next_cycle();
    check_eq("flush_start_lo", 64'(lo), 64'd12);

    run_op("divu_5_0", 2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1);
    check_eq("dbz_set2", 64'(div_by_zero), 64'd1);

    // Reset in the middle of a multiply.
    ctrl_start = 1'b1; ctrl_muldiv_op = 2'd0; rs_data = 32'd9; rt_data = 32'd9;
    #1;
    for (int c = 1; c <= 21; c++) begin
      next_cycle();
      ctrl_start = 1'b0;
      reset = (c == 20);
    end
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_dbz", 64'(div_by_zero), 64'd0);
    check_eq("midrst_hi", 64'(hi), 64'd0);
    check_eq("midrst_lo", 64'(lo), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
